// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue controller: opcodes, normaliser sources and
// reservation table entries.
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3
  } fpu_op_t;

  typedef enum logic [1:0] {
    SRC_ADD = 2'd0,
    SRC_MUL = 2'd1,
    SRC_DIV = 2'd2
  } norm_src_t;

  typedef struct packed {
    logic      valid;
    norm_src_t src;
  } res_entry_t;

  // Opcodes 4..7 are undefined; the top bit alone separates them.
  function automatic logic op_legal(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/fpu_scoreboard.sv
// Destination scoreboard: one busy bit per register, set on issue, cleared on
// writeback; a same-cycle set and clear of one register leaves it busy.
module fpu_scoreboard
  import fpu_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        set_en,
  input  logic [$clog2(NUM_REGS)-1:0] set_dest,
  input  logic                        clr_en,
  input  logic [$clog2(NUM_REGS)-1:0] clr_dest,
  input  logic [$clog2(NUM_REGS)-1:0] lookup_dest,
  output logic                        lookup_busy,
  output logic [NUM_REGS-1:0]         busy
);

  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_dest] = 1'b0;
    if (set_en) busy_next[set_dest] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_next;
  end

  assign lookup_busy = busy[lookup_dest];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue scheduler: dispatches add/sub, mul and div ops and arbitrates the
// shared normaliser. Optional divider starvation guard: FPU_DIV_STARVE_GUARD_EN.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int NUM_REGS    = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [2:0]                  req_op,
  input  logic [31:0]                 req_a,
  input  logic [31:0]                 req_b,
  input  logic [$clog2(NUM_REGS)-1:0] req_dest,
  output logic [31:0]                 fpu_a,
  output logic [31:0]                 fpu_b,
  output logic [$clog2(NUM_REGS)-1:0] fpu_dest,
  output logic                        add_start,
  output logic                        add_sub,
  output logic                        mul_start,
  output logic                        div_start,
  input  logic                        div_done,
  output logic                        div_ack,
  output logic                        norm_valid,
  output logic [1:0]                  norm_sel,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_dest,
  output logic [NUM_REGS-1:0]         busy,
  output logic                        illegal_op
);

  localparam int DEST_W = $clog2(NUM_REGS);

  // res[k] is the normaliser slot k cycles from now; res[0] is this cycle.
  res_entry_t [MUL_LATENCY:0] res;

  logic              run;
  logic              div_busy;
  logic [DEST_W-1:0] div_dest;
  logic              dest_busy;
  logic              guard_block;
  logic              div_grant;
  logic              accept;
  logic              is_legal;
  logic              is_add;
  logic              is_mul;
  logic              is_div;

  assign is_legal = op_legal(req_op);
  assign is_add   = (req_op == OP_ADD) || (req_op == OP_SUB);
  assign is_mul   = (req_op == OP_MUL);
  assign is_div   = (req_op == OP_DIV);

  always_comb begin
    req_ready = run;
    if (is_legal) begin
      if (dest_busy)                         req_ready = 1'b0;
      if (div_busy && (req_dest == div_dest)) req_ready = 1'b0;
      if (is_add && res[2].valid)            req_ready = 1'b0;
      if (is_div && div_busy)                req_ready = 1'b0;
      if ((is_add || is_mul) && guard_block) req_ready = 1'b0;
    end
  end

  assign accept = req_valid && req_ready;

  // The divider only gets the normaliser in a cycle no pipe has reserved.
  assign div_grant  = div_busy && div_done && !res[0].valid;
  assign div_ack    = div_grant;
  assign norm_valid = res[0].valid || div_grant;

  always_comb begin
    norm_sel = SRC_ADD;
    if (res[0].valid)   norm_sel = res[0].src;
    else if (div_grant) norm_sel = SRC_DIV;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run        <= 1'b0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_dest   <= '0;
      add_start  <= 1'b0;
      add_sub    <= 1'b0;
      mul_start  <= 1'b0;
      div_start  <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      run        <= 1'b1;
      add_start  <= accept && is_legal && is_add;
      mul_start  <= accept && is_legal && is_mul;
      div_start  <= accept && is_legal && is_div;
      illegal_op <= accept && !is_legal;
      if (accept) begin
        fpu_a    <= req_a;
        fpu_b    <= req_b;
        fpu_dest <= req_dest;
        add_sub  <= (req_op == OP_SUB);
      end
    end
  end

  // Shift, then write into post-shift positions: an add checked against res[2]
  // lands in res[1]; a mul lands in the top entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res <= '0;
    end else begin
      for (int i = 0; i < MUL_LATENCY; i++) res[i] <= res[i+1];
      res[MUL_LATENCY] <= '0;
      if (accept && is_add) res[1]           <= '{valid: 1'b1, src: SRC_ADD};
      if (accept && is_mul) res[MUL_LATENCY] <= '{valid: 1'b1, src: SRC_MUL};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_busy <= 1'b0;
      div_dest <= '0;
    end else if (accept && is_div) begin
      div_busy <= 1'b1;
      div_dest <= req_dest;
    end else if (div_grant) begin
      div_busy <= 1'b0;
    end
  end

`ifdef FPU_DIV_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  // Saturates at 8 so a long wait cannot wrap the guard back off.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                            starve_cnt <= '0;
    else if (div_ack)                        starve_cnt <= '0;
    else if (div_done && starve_cnt != 4'd8) starve_cnt <= starve_cnt + 4'd1;
  end

  assign guard_block = starve_cnt[3];
`else
  assign guard_block = 1'b0;
`endif

  fpu_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clock      (clock),
    .reset_n    (reset_n),
    .set_en     (accept && is_legal),
    .set_dest   (req_dest),
    .clr_en     (wb_valid),
    .clr_dest   (wb_dest),
    .lookup_dest(req_dest),
    .lookup_busy(dest_busy),
    .busy       (busy)
  );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl (MUL_LATENCY=3, NUM_REGS=32) with
// hand-computed expectations; the guard scenario runs when the macro is set.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_dest;
  logic [31:0] fpu_a, fpu_b;
  logic [4:0]  fpu_dest;
  logic        add_start, add_sub, mul_start, div_start;
  logic        div_done, div_ack;
  logic        norm_valid;
  logic [1:0]  norm_sel;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] busy;
  logic        illegal_op;

  int vectors = 0;
  int miscompares = 0;

  fpu_issue_ctrl #(.MUL_LATENCY(3), .NUM_REGS(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_dest(req_dest),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_dest(fpu_dest),
    .add_start(add_start), .add_sub(add_sub), .mul_start(mul_start),
    .div_start(div_start), .div_done(div_done), .div_ack(div_ack),
    .norm_valid(norm_valid), .norm_sel(norm_sel),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .busy(busy),
    .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] dest);
    req_valid = v;
    req_op    = op;
    req_dest  = dest;
    req_a     = 32'h1000 + 32'(dest);
    req_b     = 32'h2000 + 32'(dest);
  endtask

  task automatic wb(input logic [4:0] dest);
    wb_valid = 1'b1;
    wb_dest  = dest;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    int   k;
    logic [4:0] wb_list [8];
    wb_list = '{5'd7, 5'd8, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};

    drive(1'b0, OP_ADD, 5'd0);
    div_done = 1'b0;
    wb_valid = 1'b0;
    wb_dest  = 5'd0;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_norm_valid", {31'd0, norm_valid}, 32'd0);
    check("rst_add_start", {31'd0, add_start}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    tick();

    // ADD dest=5: start next cycle, normaliser slot one later
    drive(1'b1, OP_ADD, 5'd5);
    req_a = 32'h1111;
    req_b = 32'h2222;
    #1 check("add_ready", {31'd0, req_ready}, 32'd1);
    tick();
    drive(1'b0, OP_ADD, 5'd0);
    #1;
    check("add_start", {31'd0, add_start}, 32'd1);
    check("add_fpu_a", fpu_a, 32'h1111);
    check("add_fpu_b", fpu_b, 32'h2222);
    check("add_fpu_dest", {27'd0, fpu_dest}, 32'd5);
    check("add_busy", busy, 32'h20);
    check("add_norm_early", {31'd0, norm_valid}, 32'd0);
    tick();
    check("add_norm_valid", {31'd0, norm_valid}, 32'd1);
    check("add_norm_sel", {30'd0, norm_sel}, 32'd0);
    check("add_start_pulse", {31'd0, add_start}, 32'd0);
    tick();
    check("add_norm_done", {31'd0, norm_valid}, 32'd0);
    check("add_busy_held", busy, 32'h20);
    wb(5'd5);
    #1 check("add_busy_clr", busy, 32'd0);

    // MUL at t0, SUB at t2 collides on slot t4
    drive(1'b1, OP_MUL, 5'd9);
    #1 check("mul_ready", {31'd0, req_ready}, 32'd1);
    tick();
    drive(1'b0, OP_ADD, 5'd0);
    #1;
    check("mul_start", {31'd0, mul_start}, 32'd1);
    check("mul_no_add", {31'd0, add_start}, 32'd0);
    tick();
    drive(1'b1, OP_SUB, 5'd10);
    #1 check("slot_clash", {31'd0, req_ready}, 32'd0);
    tick();
    #1 check("slot_free", {31'd0, req_ready}, 32'd1);
    tick();
    drive(1'b0, OP_ADD, 5'd0);
    #1;
    check("sub_start", {31'd0, add_start}, 32'd1);
    check("sub_flag", {31'd0, add_sub}, 32'd1);
    check("mul_norm_valid", {31'd0, norm_valid}, 32'd1);
    check("mul_norm_sel", {30'd0, norm_sel}, 32'd1);
    check("mul_sub_busy", busy, 32'h600);
    tick();
    check("sub_norm_valid", {31'd0, norm_valid}, 32'd1);
    check("sub_norm_sel", {30'd0, norm_sel}, 32'd0);
    tick();
    check("mul_sub_idle", {31'd0, norm_valid}, 32'd0);
    wb(5'd9);
    wb(5'd10);
    #1 check("mul_sub_clr", busy, 32'd0);

    // DIV 7 then DIV 8: second waits for the ack
    drive(1'b1, OP_DIV, 5'd7);
    #1 check("div1_ready", {31'd0, req_ready}, 32'd1);
    tick();
    drive(1'b1, OP_DIV, 5'd8);
    #1;
    check("div1_start", {31'd0, div_start}, 32'd1);
    check("div2_stall", {31'd0, req_ready}, 32'd0);
    check("div1_busy", busy, 32'h80);
    tick();
    #1 check("div2_stall2", {31'd0, req_ready}, 32'd0);
    tick();
    div_done = 1'b1;
    #1;
    check("div1_ack", {31'd0, div_ack}, 32'd1);
    check("div1_norm_valid", {31'd0, norm_valid}, 32'd1);
    check("div1_norm_sel", {30'd0, norm_sel}, 32'd2);
    tick();
    div_done = 1'b0;
    #1 check("div2_ready", {31'd0, req_ready}, 32'd1);
    tick();
    drive(1'b0, OP_ADD, 5'd0);
    #1;
    check("div2_start", {31'd0, div_start}, 32'd1);
    check("div2_dest", {27'd0, fpu_dest}, 32'd8);
    check("div2_busy", busy, 32'h180);

    // add stream holds res[0]; the divider waits for the first free slot
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(1'b1, OP_ADD, 5'(11 + i));
      else       drive(1'b0, OP_ADD, 5'd0);
      div_done = (i >= 2);
      #1;
      if (i < 6)  check("stream_ready", {31'd0, req_ready}, 32'd1);
      if (i >= 2) check("stream_div_ack", {31'd0, div_ack}, {31'd0, i == 8});
      if (i >= 2) check("stream_norm_sel", {30'd0, norm_sel}, (i == 8) ? 32'd2 : 32'd0);
      tick();
    end
    div_done = 1'b0;
    for (int i = 0; i < 8; i++) wb(wb_list[i]);
    #1 check("stream_busy_clr", busy, 32'd0);

    // WAW on dest 3, then an undefined opcode
    drive(1'b1, OP_ADD, 5'd3);
    #1 check("waw_first", {31'd0, req_ready}, 32'd1);
    tick();
    #1 check("waw_stall", {31'd0, req_ready}, 32'd0);
    tick();
    #1 check("waw_stall2", {31'd0, req_ready}, 32'd0);
    wb_valid = 1'b1;
    wb_dest  = 5'd3;
    tick();
    wb_valid = 1'b0;
    #1 check("waw_release", {31'd0, req_ready}, 32'd1);
    tick();
    drive(1'b1, 3'd6, 5'd3);
    #1;
    check("waw_start", {31'd0, add_start}, 32'd1);
    check("waw_busy", busy, 32'h8);
    check("illegal_ready", {31'd0, req_ready}, 32'd1);
    tick();
    drive(1'b0, OP_ADD, 5'd0);
    #1;
    check("illegal_pulse", {31'd0, illegal_op}, 32'd1);
    check("illegal_starts", {29'd0, add_start, mul_start, div_start}, 32'd0);
    check("illegal_busy", busy, 32'h8);
    tick();
    check("illegal_one_cycle", {31'd0, illegal_op}, 32'd0);
    wb(5'd3);
    #1 check("waw_clr", busy, 32'd0);

    // simultaneous accept and writeback of dest 3: set wins
    drive(1'b1, OP_MUL, 5'd3);
    wb_valid = 1'b1;
    wb_dest  = 5'd3;
    #1 check("setwin_ready", {31'd0, req_ready}, 32'd1);
    tick();
    drive(1'b0, OP_ADD, 5'd0);
    wb_valid = 1'b0;
    #1;
    check("setwin_busy", busy, 32'h8);
    check("setwin_mul_start", {31'd0, mul_start}, 32'd1);

    // reset in the middle of a MUL
    tick();
    drive(1'b1, OP_MUL, 5'd12);
    #1;
    tick();
    drive(1'b0, OP_ADD, 5'd0);
    #1 check("rmul_start", {31'd0, mul_start}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rmul_start_clr", {31'd0, mul_start}, 32'd0);
    check("rmul_busy", busy, 32'd0);
    check("rmul_ready", {31'd0, req_ready}, 32'd0);
    check("rmul_fpu_a", fpu_a, 32'd0);
    check("rmul_norm", {31'd0, norm_valid}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | norm_valid;
    end
    check("rmul_no_norm", {31'd0, seen}, 32'd0);
    check("rmul_ready_back", {31'd0, req_ready}, 32'd1);

`ifdef FPU_DIV_STARVE_GUARD_EN
    drive(1'b1, OP_DIV, 5'd1);
    #1 check("guard_div_ready", {31'd0, req_ready}, 32'd1);
    tick();
    k = 2;
    for (int j = -2; j <= 10; j++) begin
      drive(1'b1, OP_ADD, 5'(k));
      div_done = (j >= 0);
      #1;
      if (j >= 0 && j <= 8) check("guard_ready", {31'd0, req_ready}, {31'd0, j < 8});
      if (j >= 0)           check("guard_ack", {31'd0, div_ack}, {31'd0, j == 10});
      if (req_ready) k++;
      tick();
    end
    drive(1'b0, OP_ADD, 5'd0);
    div_done = 1'b0;
    #1 check("guard_adds", k, 32'd12);
`else
    k = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Issue scheduler for the FPU cluster.
- Accepts one FPU op per cycle from the CPU decode stage and dispatches it to the add/sub pipe (1-cycle), the mul pipe (MUL_LATENCY cycles) or the iterative divider (variable latency).
- Owns a reservation schedule so results never collide on the single shared normalise/round stage, and keeps a 32-entry destination scoreboard for RAW/WAW interlock.

Parameters:
- MUL_LATENCY, 3: cycles from mul_start to mul result registered (range 2..8).
- NUM_REGS, 32: scoreboard entries; dest width is clog2(NUM_REGS).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  op request from decode
- req_ready  out  1  op accepted this cycle when req_valid and req_ready
- req_op  in  3  fpu_op_t opcode
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_dest  in  5  destination register
- fpu_a  out  32  registered operand A to all units
- fpu_b  out  32  registered operand B to all units
- fpu_dest  out  5  registered destination to add/mul pipes
- add_start  out  1  start pulse to add pipe
- add_sub  out  1  0=add, 1=sub
- mul_start  out  1  start pulse to mul pipe
- div_start  out  1  start pulse to divider
- div_done  in  1  divider result ready; held until div_ack
- div_ack  out  1  divider result taken by normaliser this cycle
- norm_valid  out  1  normaliser input is valid this cycle
- norm_sel  out  2  normaliser source: 0=add, 1=mul, 2=div
- wb_valid  in  1  normaliser writeback strobe
- wb_dest  in  5  register written back
- busy  out  32  scoreboard; bit r set while a result for r is in flight
- illegal_op  out  1  one-cycle pulse when an undefined opcode is accepted

Behaviour:
- Reset (async, reset_n=0): clear all outputs, busy, reservation table, div_busy and div_dest; req_ready=0 during reset.
  - Unit valids are not reset, so the normaliser is qualified only by norm_valid.
  - In-flight results at reset are discarded.
- Issue stage, registered. On accept, fpu_a/fpu_b/fpu_dest and exactly one start pulse are driven the following cycle.
- Reservation table res[0..MUL_LATENCY]:
  - Each entry is {valid, src}; it shifts toward 0 every cycle.
  - res[0] is this cycle's normaliser slot.
  - Add issue reserves res[2] (start+1, then the add register stage); mul issue reserves res[MUL_LATENCY+1].
  - Reservations are written into the post-shift positions.
- req_ready is low when any of the following holds:
  - busy[req_dest]=1 (WAW);
  - the target slot is already reserved;
  - op is DIV and div_busy=1;
  - the div-starvation guard is active (see Optional Feature).
- Divider: DIV issue sets div_busy and latches div_dest. When div_done=1 and res[0] is free: assert div_ack, norm_valid=1, norm_sel=2, and clear div_busy the same cycle. Otherwise div waits.
- norm_valid/norm_sel = res[0] when it is valid, else the divider grant.
- Scoreboard:
  - Set busy[req_dest] on accept of ADD/SUB/MUL/DIV.
  - Clear busy[wb_dest] on wb_valid.
  - Same dest, same cycle: set wins.
- Opcodes (fpu_op_t): 0 ADD, 1 SUB, 2 MUL, 3 DIV. Values 4–7 are accepted with ready=1; they set no busy bit, produce no start pulse, and pulse illegal_op.
- At most one start pulse per cycle; throughput is one op per cycle absent stalls.

Optional Feature:
- Macro: FPU_DIV_STARVE_GUARD_EN.
- Enabled:
  - A 4-bit counter increments each cycle div_done=1 and div_ack=0.
  - At 8, req_ready is forced low for ADD/SUB/MUL until div_ack. This drains the reservations and guarantees the div grant within MUL_LATENCY+1 cycles.
  - The counter clears on div_ack.
- Disabled: no guard; a continuous add/mul stream may starve the divider indefinitely.

Decomposition:
- Package fpu_pkg:
  - fpu_op_t enum;
  - norm_src_t (SRC_ADD, SRC_MUL, SRC_DIV);
  - res_entry_t struct {valid, norm_src_t src}.
- Sub-module fpu_scoreboard: busy vector, set/clear with set-priority, and a per-dest busy lookup.
- Reservation table and issue logic stay in the top.

Test Plan:
- ADD dest=5 accepted at t0 -> add_start at t1, norm_valid/norm_sel=0 at t2, busy[5] set t1 until wb_valid dest=5.
- MUL at t0 followed by ADD, MUL_LATENCY=3 -> MUL slot t4; ADD issued t2 would also target t4, so req_ready=0 at t2 and it is accepted at t3.
- DIV dest=7 then DIV dest=8 -> second stalls until div_ack; div_done asserted during continuous add stream -> div_ack only in first free res[0] cycle.
- Consecutive ADD dest=3, ADD dest=3 -> second stalls until wb_valid dest=3; wb_valid dest=3 with simultaneous accept dest=3 -> busy[3] remains 1.
- req_op=6 -> illegal_op one-cycle pulse, no start, busy unchanged; reset_n low mid-MUL -> all outputs 0 immediately, no norm_valid after release.
- With FPU_DIV_STARVE_GUARD_EN: div_done held during back-to-back ADDs -> after 8 cycles req_ready=0, div_ack within 2 more cycles.
